// File: rtl/tea_arbiter.sv
// tea_arbiter: shares one TEA encrypt/decrypt core between two requesters.
// Requests are granted round-robin. A granted block is latched and issued to
// the core with a one-cycle start pulse. The result is captured on core_done
// and returned to the owning requester as a one-cycle response pulse.
// Optional macro TEA_ARB_TIMEOUT_EN bounds the wait for core_done to
// TIMEOUT_CYCLES. On expiry the arbiter returns a zeroed response with
// resp_err set.
//
// state | meaning
// IDLE  | waiting for a request; grants and latches operands on acceptance
// ISSUE | core_start pulse for the latched operation
// WAIT  | operands held stable until core_done (or timeout)
// RESP  | one-cycle response to the owner, ops_done increments
module tea_arbiter #(
  parameter int WORD_W         = 32,
  parameter int KEY_W          = 128,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int OPS_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_mode,
  input  logic [2*WORD_W-1:0]   req_v0,
  input  logic [2*WORD_W-1:0]   req_v1,
  input  logic [KEY_W-1:0]      key,
  output logic                  core_start,
  output logic                  core_mode,
  output logic [WORD_W-1:0]     core_v0,
  output logic [WORD_W-1:0]     core_v1,
  output logic [KEY_W-1:0]      core_key,
  input  logic                  core_done,
  input  logic [WORD_W-1:0]     core_v0_res,
  input  logic [WORD_W-1:0]     core_v1_res,
  output logic [1:0]            resp_valid,
  output logic [WORD_W-1:0]     resp_v0,
  output logic [WORD_W-1:0]     resp_v1,
  output logic                  resp_err,
  output logic                  busy,
  output logic [OPS_W-1:0]      ops_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic   grant;       // owner of the operation in flight
  logic   last_grant;  // owner of the most recently completed operation
  logic   pick;        // requester chosen this cycle in IDLE
  logic   accept;
  logic   timeout_hit;

`ifdef TEA_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] wait_cnt;
  logic            err_q;

  // Count WAIT cycles; cleared while issuing so each operation starts at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + TO_W'(1);
    end
  end

  // The last allowed WAIT cycle is the one where the count shows TIMEOUT_CYCLES-1.
  assign timeout_hit = (state == WAIT) && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign resp_err    = (state == RESP) && err_q;
`else
  assign timeout_hit = 1'b0;
  assign resp_err    = 1'b0;
`endif

  // Round-robin choice: a lone requester wins, a tie goes away from last_grant.
  always_comb begin
    pick = 1'b0;
    if (req_valid == 2'b11) begin
      pick = ~last_grant;
    end else begin
      pick = req_valid[1];
    end
  end

  // Next-state and acceptance; acceptance is masked while reset is asserted.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if ((req_valid != 2'b00) && reset) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (core_done || timeout_hit) begin
          state_nxt = RESP;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready  = accept ? (pick ? 2'b10 : 2'b01) : 2'b00;
  assign core_start = (state == ISSUE);
  assign resp_valid = (state == RESP) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign busy       = (state != IDLE);

  // State register, operand/result latches, round-robin history and op counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      core_mode  <= 1'b0;
      core_v0    <= '0;
      core_v1    <= '0;
      core_key   <= '0;
      resp_v0    <= '0;
      resp_v1    <= '0;
      ops_done   <= '0;
`ifdef TEA_ARB_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        grant     <= pick;
        core_mode <= pick ? req_mode[1] : req_mode[0];
        core_v0   <= pick ? req_v0[2*WORD_W-1:WORD_W] : req_v0[WORD_W-1:0];
        core_v1   <= pick ? req_v1[2*WORD_W-1:WORD_W] : req_v1[WORD_W-1:0];
        core_key  <= key;
      end
      if (state == WAIT) begin
        // core_done takes priority over a coincident timeout
        if (core_done) begin
          resp_v0 <= core_v0_res;
          resp_v1 <= core_v1_res;
`ifdef TEA_ARB_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
        end else if (timeout_hit) begin
          resp_v0 <= '0;
          resp_v1 <= '0;
`ifdef TEA_ARB_TIMEOUT_EN
          err_q   <= 1'b1;
`endif
        end
      end
      if (state == RESP) begin
        ops_done   <= ops_done + OPS_W'(1);
        last_grant <= grant;
      end
    end
  end

endmodule

// File: tb/tb_tea_arbiter.sv
// Directed bench for tea_arbiter with a stub core: the stub answers
// core_start after a programmable latency, and its result is the operand XOR
// the known TEA all-zero vector. XOR is its own inverse, so an encrypt
// followed by a decrypt returns the original block.
module tb_tea_arbiter;

  localparam int WORD_W = 32;
  localparam int KEY_W  = 128;
  localparam int OPS_W  = 16;
  localparam logic [31:0] K0 = 32'h41EA3A0A;
  localparam logic [31:0] K1 = 32'h94BAA940;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_mode;
  logic [63:0]       req_v0;
  logic [63:0]       req_v1;
  logic [KEY_W-1:0]  key;
  logic              core_start;
  logic              core_mode;
  logic [31:0]       core_v0;
  logic [31:0]       core_v1;
  logic [KEY_W-1:0]  core_key;
  logic              core_done;
  logic [31:0]       core_v0_res;
  logic [31:0]       core_v1_res;
  logic [1:0]        resp_valid;
  logic [31:0]       resp_v0;
  logic [31:0]       resp_v1;
  logic              resp_err;
  logic              busy;
  logic [OPS_W-1:0]  ops_done;

  int checks = 0;
  int errors = 0;
  int lat    = 32;
  logic core_en = 1'b1;
  logic stray   = 1'b0;
  int stub_cnt;
  int starts = 0;

  tea_arbiter #(.WORD_W(WORD_W), .KEY_W(KEY_W), .TIMEOUT_CYCLES(16), .OPS_W(OPS_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_v0(req_v0), .req_v1(req_v1), .key(key),
    .core_start(core_start), .core_mode(core_mode), .core_v0(core_v0),
    .core_v1(core_v1), .core_key(core_key), .core_done(core_done),
    .core_v0_res(core_v0_res), .core_v1_res(core_v1_res),
    .resp_valid(resp_valid), .resp_v0(resp_v0), .resp_v1(resp_v1),
    .resp_err(resp_err), .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  // Stub core: done pulses lat cycles after the start cycle; stray injects a bogus done.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      stub_cnt    <= 0;
      core_done   <= 1'b0;
      core_v0_res <= '0;
      core_v1_res <= '0;
    end else begin
      core_done <= stray;
      if (core_start && core_en) begin
        stub_cnt <= lat - 1;
      end else if (stub_cnt != 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) begin
          core_done   <= 1'b1;
          core_v0_res <= core_v0 ^ K0;
          core_v1_res <= core_v1 ^ K1;
        end
      end
    end
  end

  // Count start pulses.
  always @(posedge clk) begin
    if (core_start) starts <= starts + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_resp(input int budget);
    int waited = 0;
    while (resp_valid == 2'b00 && waited < budget) begin
      cyc();
      waited++;
    end
    if (resp_valid == 2'b00) begin
      checks++;
      errors++;
      $error("FAIL wait_resp: observed no response expected one within %0d cycles", budget);
    end
  endtask

  task automatic wait_ready(input int budget);
    int waited = 0;
    while (req_ready == 2'b00 && waited < budget) begin
      cyc();
      waited++;
    end
    if (req_ready == 2'b00) begin
      checks++;
      errors++;
      $error("FAIL wait_ready: observed no grant expected one within %0d cycles", budget);
    end
  endtask

  initial begin
    int s0;
    int seen;
    logic [1:0]  exp_g;
    logic [31:0] exp_v0;

    reset = 1'b0; req_valid = 2'b00; req_mode = 2'b00;
    req_v0 = '0; req_v1 = '0; key = '0;
    cyc(3);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_start", core_start, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_ops", ops_done, 0);
    chk("rst_v0", core_v0, 0);
    reset = 1'b1;
    cyc();

    // Encrypt, requester 0, latency 32
    lat = 32;
    req_valid = 2'b01; req_mode = 2'b00; req_v0 = '0; req_v1 = '0; key = '0;
    #1;
    chk("t1_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    chk("t1_start", core_start, 1);
    chk("t1_busy", busy, 1);
    cyc(32);
    chk("t1_resp_early", resp_valid, 0);
    cyc();
    chk("t1_resp", resp_valid, 2'b01);
    chk("t1_v0", resp_v0, K0);
    chk("t1_v1", resp_v1, K1);
    chk("t1_err", resp_err, 0);
    cyc();
    chk("t1_ops", ops_done, 1);
    chk("t1_idle", busy, 0);
    chk("t1_resp_off", resp_valid, 0);

    // Decrypt round trip, requester 1
    lat = 8;
    req_valid = 2'b10; req_mode = 2'b10;
    req_v0 = {K0, 32'h0}; req_v1 = {K1, 32'h0};
    #1;
    chk("t2_ready", req_ready, 2'b10);
    cyc();
    req_valid = 2'b00;
    chk("t2_start", core_start, 1);
    chk("t2_core_v0", core_v0, K0);
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("t2_mode_wait", core_mode, 1);
    end
    wait_resp(5);
    chk("t2_resp", resp_valid, 2'b10);
    chk("t2_v0", resp_v0, 0);
    chk("t2_v1", resp_v1, 0);
    cyc();
    chk("t2_ops", ops_done, 2);

    // Contention from reset
    reset = 1'b0;
    req_valid = 2'b11; req_mode = 2'b00;
    req_v0 = {32'h2222_2222, 32'h1111_1111};
    req_v1 = {32'h4444_4444, 32'h3333_3333};
    lat = 4;
    cyc();
    chk("t3_rst_ready", req_ready, 0);
    chk("t3_rst_ops", ops_done, 0);
    s0 = starts;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_v0 = (k % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222;
      wait_ready(20);
      chk("t3_grant", req_ready, exp_g);
      cyc();
      chk("t3_start", core_start, 1);
      chk("t3_core_v0", core_v0, exp_v0);
      wait_resp(20);
      chk("t3_owner", resp_valid, exp_g);
      chk("t3_data", resp_v0, exp_v0 ^ K0);
      cyc();
    end
    req_valid = 2'b00;
    chk("t3_starts", starts - s0, 4);
    chk("t3_ops", ops_done, 4);

    // Stray done in IDLE, late done in ISSUE
    lat = 6;
    stray = 1'b1;
    cyc();
    stray = 1'b0;
    chk("t4_idle_busy", busy, 0);
    cyc();
    chk("t4_idle_resp", resp_valid, 0);
    cyc(2);
    chk("t4_idle_ops", ops_done, 4);
    req_valid = 2'b01; req_mode = 2'b00;
    req_v0 = {32'h0, 32'hAAAA_0001}; req_v1 = {32'h0, 32'h5555_0002};
    stray = 1'b1;
    #1;
    chk("t4_ready", req_ready, 2'b01);
    cyc();
    stray = 1'b0; req_valid = 2'b00;
    chk("t4_start", core_start, 1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t4_wait_resp", resp_valid, 0);
      chk("t4_v0_stable", core_v0, 32'hAAAA_0001);
      chk("t4_v1_stable", core_v1, 32'h5555_0002);
    end
    cyc();
    chk("t4_resp", resp_valid, 2'b01);
    chk("t4_v0", resp_v0, 32'hEB40_3A0B);
    chk("t4_v1", resp_v1, 32'hC1EF_A942);
    cyc();
    chk("t4_ops", ops_done, 5);

    // Reset mid-WAIT
    lat = 20;
    req_valid = 2'b01; req_v0 = {32'h0, 32'h1234_5678}; req_v1 = '0;
    #1;
    chk("t5_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    chk("t5_start", core_start, 1);
    cyc(5);
    reset = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_resp", resp_valid, 0);
    chk("t5_ops", ops_done, 0);
    chk("t5_core_v0", core_v0, 0);
    cyc(2);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      cyc();
      if (resp_valid != 2'b00) seen++;
    end
    chk("t5_no_resp", seen, 0);
    lat = 3;
    req_valid = 2'b01; req_v0 = '0; req_v1 = '0;
    #1;
    chk("t5_ready2", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    wait_resp(10);
    chk("t5_resp2", resp_valid, 2'b01);
    chk("t5_v0_2", resp_v0, K0);
    cyc();
    chk("t5_ops2", ops_done, 1);

`ifdef TEA_ARB_TIMEOUT_EN
    // Core never completes: abort after 16 WAIT cycles
    core_en = 1'b0;
    req_valid = 2'b01; req_v0 = {32'h0, 32'h0BAD_F00D}; req_v1 = '0;
    #1;
    chk("t6_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    cyc(16);
    chk("t6_resp_early", resp_valid, 0);
    cyc();
    chk("t6_resp", resp_valid, 2'b01);
    chk("t6_err", resp_err, 1);
    chk("t6_v0", resp_v0, 0);
    chk("t6_v1", resp_v1, 0);
    cyc();
    chk("t6_busy", busy, 0);
    chk("t6_ops", ops_done, 2);
    core_en = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
